// File: rtl/scic_pkg.sv
// Shared definitions for the small accumulator CPU: opcode values, instruction
// field positions and the fetch sequencer state encoding.
package scic_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SHL = 4'h2;
  localparam logic [3:0] OP_SHR = 4'h3;
  localparam logic [3:0] OP_LI  = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_BR  = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;

  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 28;
  localparam int OPERAND_MSB = 15;
  localparam int OPERAND_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_ISSUE  = 2'd3
  } seq_state_e;

  // Opcodes 0xA..0xF are unassigned; the sequencer skips them like a NOP.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= 4'hA);
  endfunction

endpackage

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch/decode sequencer: owns the PC, reads the instruction ROM,
// resolves branches and NOPs locally and hands datapath ops over valid/ready.
module instr_fetch_sequencer
  import scic_pkg::*;
#(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int OPERAND_WIDTH = 16,
  parameter int RESET_PC      = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run,
  output logic [ADDR_WIDTH-1:0]    rom_address,
  output logic                     rom_cs,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [3:0]               opcode,
  output logic [OPERAND_WIDTH-1:0] operand,
  output logic [ADDR_WIDTH-1:0]    pc,
  output logic                     illegal_op
);

  seq_state_e               state_q;
  logic [ADDR_WIDTH-1:0]    pc_q;
  logic [DATA_WIDTH-1:0]    ir_q;
  logic                     op_valid_q;
  logic [3:0]               opcode_q;
  logic [OPERAND_WIDTH-1:0] operand_q;
  logic                     illegal_q;

  logic [3:0]               ir_opcode;
  logic [ADDR_WIDTH-1:0]    pc_inc;
  logic                     unused_ir_bits;

  assign ir_opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign pc_inc         = pc_q + 1'b1;
  assign unused_ir_bits = ^ir_q[OPCODE_LSB-1:OPERAND_MSB+1];

  // The ROM is read combinationally, so address and select follow the PC only in FETCH.
  assign rom_cs      = (state_q == ST_FETCH);
  assign rom_address = rom_cs ? pc_q : '0;
  assign pc          = pc_q;
  assign op_valid    = op_valid_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign illegal_op  = illegal_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= ADDR_WIDTH'(RESET_PC);
      ir_q       <= '0;
      op_valid_q <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          ir_q    <= rom_data;
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          // Branches and NOPs never reach the datapath; run is only honoured here.
          if (ir_opcode == OP_BR) begin
            pc_q    <= ir_q[ADDR_WIDTH-1:0];
            state_q <= run ? ST_FETCH : ST_IDLE;
          end else if (ir_opcode == OP_NOP || is_illegal_op(ir_opcode)) begin
            pc_q      <= pc_inc;
            illegal_q <= illegal_q | is_illegal_op(ir_opcode);
            state_q   <= run ? ST_FETCH : ST_IDLE;
          end else begin
            opcode_q   <= ir_opcode;
            operand_q  <= ir_q[OPERAND_WIDTH-1:0];
            op_valid_q <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            pc_q       <= pc_inc;
            state_q    <= run ? ST_FETCH : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with a combinational 32-word ROM model.
module tb_instr_fetch_sequencer;

  logic        clk;
  logic        resetN;
  logic        run;
  logic [4:0]  romAddress;
  logic        romCs;
  logic [31:0] romData;
  logic        opValid;
  logic        opReady;
  logic [3:0]  opcode;
  logic [15:0] operand;
  logic [4:0]  pc;
  logic        illegalOp;

  logic [31:0] rom [32];
  int assertCount = 0;
  int failCount   = 0;

  assign romData = rom[romAddress];

  instr_fetch_sequencer dut (
    .clk         (clk),
    .reset_n     (resetN),
    .run         (run),
    .rom_address (romAddress),
    .rom_cs      (romCs),
    .rom_data    (romData),
    .op_valid    (opValid),
    .op_ready    (opReady),
    .opcode      (opcode),
    .operand     (operand),
    .pc          (pc),
    .illegal_op  (illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
  endtask

  task automatic applyStimulus(input logic runVal, input logic readyVal);
    run     = runVal;
    opReady = readyVal;
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    stepCycle();
    stepCycle();
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0;
    applyStimulus(1'b1, 1'b1);
    clearRom();

    // Reset state and first datapath instruction with zero-wait handshake
    rom[0] = 32'h4000_000F;
    stepCycle();
    stepCycle();
    checkOutput("rst_rom_cs", romCs, 0);
    checkOutput("rst_op_valid", opValid, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_rom_addr", romAddress, 0);
    checkOutput("rst_illegal", illegalOp, 0);
    resetN = 1'b1;
    stepCycle();
    checkOutput("c1_rom_cs", romCs, 1);
    checkOutput("c1_rom_addr", romAddress, 0);
    stepCycle();
    checkOutput("c2_op_valid", opValid, 0);
    checkOutput("c2_rom_cs", romCs, 0);
    stepCycle();
    checkOutput("c3_op_valid", opValid, 1);
    checkOutput("c3_opcode", opcode, 4);
    checkOutput("c3_operand", operand, 32'h000F);
    stepCycle();
    checkOutput("c4_pc", pc, 1);
    checkOutput("c4_rom_addr", romAddress, 1);
    checkOutput("c4_rom_cs", romCs, 1);
    checkOutput("c4_op_valid", opValid, 0);

    // Branch chain: 0 -> 5 -> 2 -> 31 (0xFFFF target) -> NOP wraps to 0
    clearRom();
    rom[0]  = 32'h8000_0005;
    rom[5]  = 32'h8000_0002;
    rom[2]  = 32'h8000_FFFF;
    applyReset();
    stepCycle();
    checkOutput("br_fetch0", romAddress, 0);
    stepCycle();
    stepCycle();
    checkOutput("br_fetch5_cs", romCs, 1);
    checkOutput("br_fetch5", romAddress, 5);
    stepCycle();
    checkOutput("br_dec_valid", opValid, 0);
    stepCycle();
    checkOutput("br_fetch2_cs", romCs, 1);
    checkOutput("br_fetch2", romAddress, 2);
    stepCycle();
    stepCycle();
    checkOutput("br_ffff_pc", pc, 31);
    checkOutput("br_ffff_addr", romAddress, 31);
    stepCycle();
    stepCycle();
    checkOutput("wrap_addr", romAddress, 0);
    checkOutput("wrap_cs", romCs, 1);

    // Back-pressure: op held stable while op_ready is low
    clearRom();
    rom[0] = 32'h7000_005F;
    applyStimulus(1'b1, 1'b0);
    applyReset();
    stepCycle();
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("hold_valid", opValid, 1);
      checkOutput("hold_opcode", opcode, 7);
      checkOutput("hold_operand", operand, 32'h005F);
      checkOutput("hold_pc", pc, 0);
    end
    opReady = 1'b1;
    stepCycle();
    checkOutput("acc_valid", opValid, 0);
    checkOutput("acc_pc", pc, 1);
    checkOutput("acc_addr", romAddress, 1);
    checkOutput("acc_opcode_kept", opcode, 7);

    // Illegal opcode is skipped and the flag stays sticky until reset
    clearRom();
    rom[0] = 32'hC000_0000;
    rom[1] = 32'h1000_0001;
    applyReset();
    stepCycle();
    stepCycle();
    checkOutput("ill_before", illegalOp, 0);
    stepCycle();
    checkOutput("ill_set", illegalOp, 1);
    checkOutput("ill_next_addr", romAddress, 1);
    stepCycle();
    stepCycle();
    checkOutput("ill_issue_valid", opValid, 1);
    checkOutput("ill_issue_opcode", opcode, 1);
    checkOutput("ill_sticky1", illegalOp, 1);
    stepCycle();
    checkOutput("ill_sticky2", illegalOp, 1);
    checkOutput("ill_fetch2", romAddress, 2);
    resetN = 1'b0;
    #1;
    checkOutput("ill_cleared", illegalOp, 0);

    // Run dropped during ISSUE at pc=3, then resumed; finally reset mid-ISSUE
    clearRom();
    rom[3] = 32'h1000_005F;
    rom[4] = 32'h9000_0001;
    applyStimulus(1'b1, 1'b0);
    applyReset();
    begin
      int budget;
      budget = 0;
      while (opValid !== 1'b1 && budget < 20) begin
        stepCycle();
        budget++;
      end
      checkOutput("run_issue_seen", opValid, 1);
    end
    checkOutput("run_issue_pc", pc, 3);
    checkOutput("run_issue_opcode", opcode, 1);
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    checkOutput("park_valid", opValid, 0);
    checkOutput("park_pc", pc, 4);
    checkOutput("park_cs", romCs, 0);
    stepCycle();
    checkOutput("park_cs_hold", romCs, 0);
    checkOutput("park_pc_hold", pc, 4);
    applyStimulus(1'b1, 1'b0);
    stepCycle();
    checkOutput("resume_cs", romCs, 1);
    checkOutput("resume_addr", romAddress, 4);
    stepCycle();
    stepCycle();
    checkOutput("rst_mid_pre", opValid, 1);
    checkOutput("rst_mid_opcode", opcode, 9);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("rst_mid_valid", opValid, 0);
    checkOutput("rst_mid_pc", pc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Read side of the 32-entry instruction ROM: drives ROM address/chip-select, captures the 32-bit instruction word, decodes the opcode and handles branches and NOPs internally.
- Issues every other instruction to the accumulator datapath over a valid/ready handshake.
- Sits between the instruction ROM and the AC/ALU/store datapath and is the program counter owner for the CPU.

Parameters:
- ADDR_WIDTH, 5, ROM address / PC width (32 words).
- DATA_WIDTH, 32, instruction word width.
- OPERAND_WIDTH, 16, operand field width (bits 15:0).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  enable; when low, the sequencer parks in IDLE at the next fetch boundary.
- rom_address  out  ADDR_WIDTH  ROM word address.
- rom_cs  out  1  ROM chip select.
- rom_data  in  DATA_WIDTH  ROM instruction word; combinational from rom_address.
- op_valid  out  1  decoded instruction is presented to the datapath.
- op_ready  in  1  datapath accepts and completes the presented instruction.
- opcode  out  4  instruction bits 31:28.
- operand  out  OPERAND_WIDTH  instruction bits 15:0.
- pc  out  ADDR_WIDTH  current program counter (debug).
- illegal_op  out  1  sticky flag, set on any opcode 0xA–0xF.

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE, pc=RESET_PC, ir=0. All outputs 0: rom_cs, rom_address, op_valid, opcode, operand, illegal_op. The ROM is never selected during reset.
- FSM states: IDLE, FETCH, DECODE, ISSUE.
- IDLE:
  - rom_cs=0, op_valid=0.
  - run=1 → FETCH next cycle.
- FETCH:
  - rom_cs=1, rom_address=pc, combinational from the pc register.
  - At the clock edge ending FETCH: ir<=rom_data, then → DECODE.
- DECODE (single cycle, rom_cs=0). Branch on ir[31:28]:
  - 0x8 (BR): pc<=ir[ADDR_WIDTH-1:0]; upper operand bits are ignored.
  - 0x0 (NOP): pc<=pc+1.
  - 0xA–0xF: treated as NOP, pc<=pc+1, illegal_op<=1 (stays set until reset).
  - 0x1–0x7, 0x9: opcode<=ir[31:28], operand<=ir[15:0], op_valid<=1 → ISSUE.
  - Branch/NOP/illegal: → FETCH if run=1, else → IDLE.
  - ISSUE-bound opcodes → ISSUE regardless of run.
- ISSUE:
  - op_valid, opcode and operand are held stable until op_ready=1 is sampled high.
  - On op_ready: op_valid<=0, pc<=pc+1, → FETCH if run=1, else IDLE.
  - op_ready while op_valid=0 is ignored.
  - op_ready high in the same cycle op_valid first rises is accepted (zero-wait handshake).
- Latency:
  - Datapath instruction: 3 cycles (FETCH, DECODE, ISSUE) with op_ready tied high.
  - Branch/NOP: 2 cycles.
- Arithmetic: pc increments modulo 2^ADDR_WIDTH, so 31+1 → 0 with no flag. A branch target of 0xFFFF yields pc=0x1F.
- run dropped mid-instruction: the current instruction always completes (DECODE, and ISSUE through acceptance). Parking in IDLE happens only at the fetch boundary, with pc already pointing to the next instruction. Raising run resumes at that pc.
- Reset mid-ISSUE: op_valid drops immediately (asynchronous); the datapath must treat the dropped instruction as never issued.
- opcode/operand keep their last issued values outside ISSUE. They are qualified only by op_valid.

Decomposition:
- Shared package scic_pkg holds:
  - 4-bit opcode constants: OP_NOP=0, OP_ADD=1, OP_SHL=2, OP_SHR=3, OP_LI=4, OP_LD=5, OP_OR=6, OP_ST=7, OP_BR=8, OP_AND=9.
  - FSM state encoding.
  - Instruction field bit positions: opcode 31:28, operand 15:0.
- The ROM and datapath share this package.
- No sub-module; a single FSM plus PC/IR registers.

Test Plan:
- Reset held, rom_data=0x4000_000F → rom_cs=0, op_valid=0, pc=0. After release with run=1: rom_cs=1 and rom_address=0 in the first cycle.
- ROM word 0=0x4000_000F, op_ready tied 1 → op_valid on cycle 3 with opcode=4, operand=0x000F; pc=1 and rom_address=1 on cycle 4.
- Word 5=0x8000_0002 → no op_valid; next fetch address=2; exactly 2 cycles between fetches.
- Word 0=0x7000_005F, op_ready held low for 4 cycles → opcode=7 and operand=0x005F stable, pc=0 throughout. Single acceptance on op_ready; pc=1.
- pc=31 with word 31=0x0000_0000 (NOP) → next fetch address=0. Word 0=0xC000_0000 → illegal_op=1 and stays 1 across later instructions until reset_n pulses low.
- run dropped during ISSUE of 0x1000_005F at pc=3 → instruction accepted, state IDLE with pc=4, rom_cs=0. Run re-raised → fetch at address 4.
